// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RV32I control path.
// Holds the main-FSM state encoding, the supported major opcodes, the
// 2-bit ALUOp encoding (also consumed by the ALU control decoder), and
// the datapath mux select encodings driven by the controller.
package ctrl_pkg;

  // Main FSM states; the numeric value is exported on state_o for debug.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Major opcodes (instruction[6:0]) understood by the controller.
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALUOp: tells the ALU control decoder what to do.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // SrcA mux.
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RD1   = 2'b10;

  // SrcB mux.
  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result mux.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format select.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // True for any opcode the FSM can execute; everything else traps.
  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/imm_src_dec.sv
// imm_src_dec: selects the immediate format from the opcode.
// Purely combinational and independent of FSM state, so the immediate is
// valid in DECODE when the branch target is computed.
// Ports:
//   opcode  - instruction[6:0] from the IR
//   imm_src - immediate format (I, S, B, J)
module imm_src_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, drives datapath mux
// selects and enables, handshakes with unified memory and counts retired
// instructions.
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   opcode        - instruction[6:0] from the IR
//   zero          - ALU zero flag (branch decision in BEQ)
//   mem_ready     - memory completes the current request this cycle
//   mem_req       - memory access request
//   mem_write     - write strobe, qualified by mem_req
//   adr_src       - memory address select (0 PC, 1 ALUOut)
//   ir_write      - load IR and OldPC
//   pc_write      - PC load enable
//   reg_write     - register file write enable
//   alu_src_a/b   - ALU operand selects
//   result_src    - result mux select
//   imm_src       - immediate format
//   alu_op        - ALUOp to the ALU control decoder
//   retire        - one-cycle pulse when an instruction completes
//   illegal       - high while in TRAP
//   instret       - retired-instruction count (wraps)
//   state_o       - current state, debug only
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  imm_src_dec u_imm_src_dec (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  // Outputs decode directly from state_q, so an asynchronous reset
  // forces the FETCH outputs (e.g. drops mem_write) without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!is_legal_op(opcode)) begin
          state_d = S_TRAP;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECR;
            OP_ITYPE:     state_d = S_EXECI;
            OP_BEQ:       state_d = S_BEQ;
            OP_JAL:       state_d = S_JAL;
            default:      state_d = S_TRAP;
          endcase
        end
      end
      // Only lw and sw reach MEMADR, so anything that is not lw is a store.
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      // JAL writes the link address (OldPC+4 left in ALUOut) via ALUWB.
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RD2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_OP_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      // PC+4 goes straight from the ALU into PC when the fetch completes.
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_OP_ADD;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      // Speculatively compute the branch target OldPC+imm into ALUOut.
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = mem_ready;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      // Compare via subtract; the target computed in DECODE sits in ALUOut.
      S_BEQ: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_RD2;
        alu_op     = ALU_OP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        retire     = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_OP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // Natural modulo-2^CNT_W wrap of the counter.
  always_comb begin
    instret_d = instret_q + CNT_W'(retire);
  end

  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// Two instances share clk/opcode/zero/mem_ready: dut0 halts on illegal
// opcodes, dut1 recovers after one TRAP cycle and is held in reset until
// its own test. Stimulus pushes one expected record per cycle; a monitor
// pops and compares at the falling edge.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n;
  logic [6:0] opcode;
  logic       zero, memReady;

  logic [1:0]  memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, retireW, illegalW;
  logic [1:0]  aluSrcA [2];
  logic [1:0]  aluSrcB [2];
  logic [1:0]  resultSrc [2];
  logic [1:0]  immSrc [2];
  logic [1:0]  aluOp [2];
  logic [31:0] instret [2];
  logic [3:0]  stateO [2];

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(memReady),
    .mem_req(memReq[0]), .mem_write(memWrite[0]), .adr_src(adrSrc[0]),
    .ir_write(irWrite[0]), .pc_write(pcWrite[0]), .reg_write(regWrite[0]),
    .alu_src_a(aluSrcA[0]), .alu_src_b(aluSrcB[0]), .result_src(resultSrc[0]),
    .imm_src(immSrc[0]), .alu_op(aluOp[0]), .retire(retireW[0]),
    .illegal(illegalW[0]), .instret(instret[0]), .state_o(stateO[0])
  );

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode), .zero(zero), .mem_ready(memReady),
    .mem_req(memReq[1]), .mem_write(memWrite[1]), .adr_src(adrSrc[1]),
    .ir_write(irWrite[1]), .pc_write(pcWrite[1]), .reg_write(regWrite[1]),
    .alu_src_a(aluSrcA[1]), .alu_src_b(aluSrcB[1]), .result_src(resultSrc[1]),
    .imm_src(immSrc[1]), .alu_op(aluOp[1]), .retire(retireW[1]),
    .illegal(illegalW[1]), .instret(instret[1]), .state_o(stateO[1])
  );

  typedef struct packed {
    logic [3:0] st;
    logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite;
    logic [1:0] aSel, bSel, resSel, immSel, aluOp;
    logic       retire, illegal;
  } outs_t;

  typedef struct {
    outs_t       o;
    logic [31:0] cnt;
    int          inst;
    int          tag;
  } rec_t;

  rec_t        sbQ[$];
  int          totalCnt = 0;
  int          badCnt   = 0;
  int          tagN     = 0;
  logic [31:0] cnt0     = 0;
  logic [31:0] cnt1     = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Expected controller outputs for a state, written from the state table.
  function automatic outs_t expOut(input state_t s, input logic [6:0] op,
                                   input logic z, input logic mr);
    outs_t o;
    o        = '0;
    o.st     = 4'(s);
    o.immSel = (op == 7'b0100011) ? 2'b01 :
               (op == 7'b1100011) ? 2'b10 :
               (op == 7'b1101111) ? 2'b11 : 2'b00;
    case (s)
      S_FETCH:    begin o.memReq = 1; o.bSel = 2'b10; o.resSel = 2'b10; o.irWrite = mr; o.pcWrite = mr; end
      S_DECODE:   begin o.aSel = 2'b01; o.bSel = 2'b01; end
      S_MEMADR:   begin o.aSel = 2'b10; o.bSel = 2'b01; end
      S_MEMREAD:  begin o.memReq = 1; o.adrSrc = 1; end
      S_MEMWRITE: begin o.memReq = 1; o.memWrite = 1; o.adrSrc = 1; o.retire = mr; end
      S_MEMWB:    begin o.resSel = 2'b01; o.regWrite = 1; o.retire = 1; end
      S_EXECR:    begin o.aSel = 2'b10; o.bSel = 2'b00; o.aluOp = 2'b10; end
      S_EXECI:    begin o.aSel = 2'b10; o.bSel = 2'b01; o.aluOp = 2'b10; end
      S_ALUWB:    begin o.regWrite = 1; o.retire = 1; end
      S_BEQ:      begin o.aSel = 2'b10; o.aluOp = 2'b01; o.pcWrite = z; o.retire = 1; end
      S_JAL:      begin o.aSel = 2'b01; o.bSel = 2'b10; o.pcWrite = 1; end
      S_TRAP:     begin o.illegal = 1; end
      default:    begin o.illegal = 0; end
    endcase
    return o;
  endfunction

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input int inst, input int tag,
                             input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s dut%0d step %0d: got %0h expected %0h", name, inst, tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what the DUT should show this cycle,
  // then advance to just after the next rising edge.
  task automatic applyStimulus(input state_t s, input logic [6:0] op,
                               input logic z, input logic mr, input int inst);
    rec_t r;
    opcode   = op;
    zero     = z;
    memReady = mr;
    r.o      = expOut(s, op, z, mr);
    r.cnt    = (inst == 0) ? cnt0 : cnt1;
    r.inst   = inst;
    r.tag    = tagN++;
    sbQ.push_back(r);
    @(posedge clk);
    #1;
    if (r.o.retire) begin
      if (inst == 0) cnt0++;
      else           cnt1++;
    end
  endtask

  // Monitor: one record per cycle, compared at the falling edge.
  initial begin
    rec_t  r;
    outs_t a;
    int    k;
    forever begin
      @(negedge clk);
      if (sbQ.size() != 0) begin
        r = sbQ.pop_front();
        k = r.inst;
        a = '0;
        a.st = stateO[k];       a.memReq = memReq[k];     a.memWrite = memWrite[k];
        a.adrSrc = adrSrc[k];   a.irWrite = irWrite[k];   a.pcWrite = pcWrite[k];
        a.regWrite = regWrite[k]; a.aSel = aluSrcA[k];    a.bSel = aluSrcB[k];
        a.resSel = resultSrc[k]; a.immSel = immSrc[k];    a.aluOp = aluOp[k];
        a.retire = retireW[k];  a.illegal = illegalW[k];
        checkOutput("state",      k, r.tag, 32'(a.st),       32'(r.o.st));
        checkOutput("mem_req",    k, r.tag, 32'(a.memReq),   32'(r.o.memReq));
        checkOutput("mem_write",  k, r.tag, 32'(a.memWrite), 32'(r.o.memWrite));
        checkOutput("adr_src",    k, r.tag, 32'(a.adrSrc),   32'(r.o.adrSrc));
        checkOutput("ir_write",   k, r.tag, 32'(a.irWrite),  32'(r.o.irWrite));
        checkOutput("pc_write",   k, r.tag, 32'(a.pcWrite),  32'(r.o.pcWrite));
        checkOutput("reg_write",  k, r.tag, 32'(a.regWrite), 32'(r.o.regWrite));
        checkOutput("alu_src_a",  k, r.tag, 32'(a.aSel),     32'(r.o.aSel));
        checkOutput("alu_src_b",  k, r.tag, 32'(a.bSel),     32'(r.o.bSel));
        checkOutput("result_src", k, r.tag, 32'(a.resSel),   32'(r.o.resSel));
        checkOutput("imm_src",    k, r.tag, 32'(a.immSel),   32'(r.o.immSel));
        checkOutput("alu_op",     k, r.tag, 32'(a.aluOp),    32'(r.o.aluOp));
        checkOutput("retire",     k, r.tag, 32'(a.retire),   32'(r.o.retire));
        checkOutput("illegal",    k, r.tag, 32'(a.illegal),  32'(r.o.illegal));
        checkOutput("instret",    k, r.tag, instret[k],      r.cnt);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    rst2_n   = 1'b0;
    opcode   = RT;
    zero     = 1'b0;
    memReady = 1'b0;
    @(posedge clk);
    #1;
    // Reset outputs.
    applyStimulus(S_FETCH, RT, 0, 0, 0);
    rst_n = 1'b1;

    // R-type, no wait states.
    applyStimulus(S_FETCH,  RT, 0, 1, 0);
    applyStimulus(S_DECODE, RT, 0, 1, 0);
    applyStimulus(S_EXECR,  RT, 0, 1, 0);
    applyStimulus(S_ALUWB,  RT, 0, 1, 0);

    // lw: 3 FETCH waits, 2 MEMREAD waits -> 10 cycles.
    for (int i = 0; i < 3; i++) applyStimulus(S_FETCH, LW, 0, 0, 0);
    applyStimulus(S_FETCH,  LW, 0, 1, 0);
    applyStimulus(S_DECODE, LW, 0, 1, 0);
    applyStimulus(S_MEMADR, LW, 0, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(S_MEMREAD, LW, 0, 0, 0);
    applyStimulus(S_MEMREAD, LW, 0, 1, 0);
    applyStimulus(S_MEMWB,   LW, 0, 0, 0);

    // beq taken, then not taken.
    applyStimulus(S_FETCH,  BQ, 0, 1, 0);
    applyStimulus(S_DECODE, BQ, 1, 1, 0);
    applyStimulus(S_BEQ,    BQ, 1, 1, 0);
    applyStimulus(S_FETCH,  BQ, 1, 1, 0);
    applyStimulus(S_DECODE, BQ, 0, 0, 0);
    applyStimulus(S_BEQ,    BQ, 0, 1, 0);

    // I-type and jal.
    applyStimulus(S_FETCH,  IT, 0, 1, 0);
    applyStimulus(S_DECODE, IT, 0, 1, 0);
    applyStimulus(S_EXECI,  IT, 0, 1, 0);
    applyStimulus(S_ALUWB,  IT, 0, 1, 0);
    applyStimulus(S_FETCH,  JL, 0, 1, 0);
    applyStimulus(S_DECODE, JL, 0, 1, 0);
    applyStimulus(S_JAL,    JL, 0, 1, 0);
    applyStimulus(S_ALUWB,  JL, 0, 1, 0);

    // sw with two MEMWRITE wait states.
    applyStimulus(S_FETCH,    SW, 0, 1, 0);
    applyStimulus(S_DECODE,   SW, 0, 1, 0);
    applyStimulus(S_MEMADR,   SW, 0, 0, 0);
    applyStimulus(S_MEMWRITE, SW, 0, 0, 0);
    applyStimulus(S_MEMWRITE, SW, 0, 0, 0);
    applyStimulus(S_MEMWRITE, SW, 0, 1, 0);

    // sw interrupted by reset in MEMWRITE.
    applyStimulus(S_FETCH,    SW, 0, 1, 0);
    applyStimulus(S_DECODE,   SW, 0, 1, 0);
    applyStimulus(S_MEMADR,   SW, 0, 1, 0);
    applyStimulus(S_MEMWRITE, SW, 0, 0, 0);
    begin
      rec_t r;
      memReady = 1'b0;
      rst_n    = 1'b0;
      cnt0     = 0;
      r.o      = expOut(S_FETCH, SW, 0, 0);
      r.cnt    = 0;
      r.inst   = 0;
      r.tag    = tagN++;
      sbQ.push_back(r);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    applyStimulus(S_FETCH,  RT, 0, 1, 0);
    applyStimulus(S_DECODE, RT, 0, 1, 0);
    applyStimulus(S_EXECR,  RT, 0, 1, 0);
    applyStimulus(S_ALUWB,  RT, 0, 1, 0);

    // Illegal opcode, halting instance: TRAP sticks, no retire.
    applyStimulus(S_FETCH,  BAD, 0, 1, 0);
    applyStimulus(S_DECODE, BAD, 0, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(S_TRAP, BAD, 0, 1, 0);

    // Illegal opcode, recovering instance: one TRAP cycle then FETCH.
    rst2_n = 1'b1;
    applyStimulus(S_FETCH,  BAD, 0, 1, 1);
    applyStimulus(S_DECODE, BAD, 0, 1, 1);
    applyStimulus(S_TRAP,   BAD, 0, 1, 1);
    applyStimulus(S_FETCH,  BAD, 0, 0, 1);
    applyStimulus(S_FETCH,  BAD, 0, 0, 1);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 0, tagN, 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
